// File: rtl/sd_sector_streamer.sv
// -----------------------------------------------------------------------------
// sd_sector_streamer
//
// Reads a run of consecutive sectors through sd_controller, buffers the bytes
// in an internal first-word-fall-through FIFO and presents them on a
// valid/ready byte stream.
//
// Optional feature macro: SD_STREAM_CHECKSUM_EN
//   defined   -> checksum_out is the 16-bit wraparound sum of all bytes pushed
//                since the last start.
//   undefined -> checksum_out is tied to zero and no adder is built.
//
// Ports
//   clk_in, rst_in          clock, synchronous active-high reset
//   start_in                one-cycle pulse, begins a stream (ignored while busy)
//   start_addr_in[31:0]     first sector address, sampled on start
//   num_sectors_in[15:0]    sectors to read, 0 = continuous until stop
//   stop_in                 ends the stream at the next sector boundary
//   sd_ready_in             sd_controller ready
//   sd_byte_available_in    sd_controller byte strobe (level)
//   sd_dout_in[7:0]         sd_controller read data
//   sd_rd_out               read request to sd_controller
//   sd_addr_out[31:0]       current sector address
//   data_out[7:0]           stream byte
//   valid_out               stream byte valid (FIFO non-empty)
//   ready_in                consumer accepts
//   busy_out                stream in progress
//   done_out                one-cycle completion pulse
//   sector_count_out[15:0]  sectors completed in the current stream
//   spurious_out            sticky, byte strobe seen outside RECEIVE while busy
//   checksum_out[15:0]      running byte sum (see macro above)
// -----------------------------------------------------------------------------
module sd_sector_streamer #(
    parameter int FIFO_DEPTH   = 1024,
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_STEP    = 512
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        start_in,
    input  logic [31:0] start_addr_in,
    input  logic [15:0] num_sectors_in,
    input  logic        stop_in,
    input  logic        sd_ready_in,
    input  logic        sd_byte_available_in,
    input  logic [7:0]  sd_dout_in,
    output logic        sd_rd_out,
    output logic [31:0] sd_addr_out,
    output logic [7:0]  data_out,
    output logic        valid_out,
    input  logic        ready_in,
    output logic        busy_out,
    output logic        done_out,
    output logic [15:0] sector_count_out,
    output logic        spurious_out,
    output logic [15:0] checksum_out
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int BCNT_W = $clog2(SECTOR_BYTES);

    localparam logic [2:0] S_IDLE       = 3'd0;
    localparam logic [2:0] S_WAIT_READY = 3'd1;
    localparam logic [2:0] S_ISSUE      = 3'd2;
    localparam logic [2:0] S_RECEIVE    = 3'd3;
    localparam logic [2:0] S_NEXT       = 3'd4;
    localparam logic [2:0] S_DONE       = 3'd5;

    localparam logic [PTR_W:0]    DEPTH_FULL   = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    SECTOR_SPACE = (PTR_W+1)'(SECTOR_BYTES);
    localparam logic [BCNT_W-1:0] LAST_BYTE    = BCNT_W'(SECTOR_BYTES - 1);
    localparam logic [31:0]       ADDR_INC     = 32'(ADDR_STEP);

    // Control state
    logic [2:0]        state_q, state_d;
    logic [31:0]       addr_q, addr_d;
    logic [15:0]       num_q, num_d;
    logic [15:0]       scount_q, scount_d;
    logic              spurious_q, spurious_d;
    logic              stop_pend_q, stop_pend_d;
    logic [BCNT_W-1:0] bcnt_q, bcnt_d;

    // Byte capture: strobe edge is registered, the FIFO write happens one cycle later
    logic              avail_prev_q;
    logic              push_q, push_d;
    logic [7:0]        push_data_q;

    // FIFO storage and pointers
    logic [7:0]        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
    logic [PTR_W:0]    fill_q, fill_d;

    logic              strobe_edge_s;
    logic              write_s;
    logic              pop_s;
    logic              not_empty_s;
    logic [PTR_W:0]    free_s;

    assign strobe_edge_s = sd_byte_available_in & ~avail_prev_q;
    assign not_empty_s   = (fill_q != {(PTR_W+1){1'b0}});
    assign write_s       = push_q & (fill_q != DEPTH_FULL);
    assign pop_s         = not_empty_s & ready_in;
    assign free_s        = DEPTH_FULL - fill_q;

    // Next-state and datapath control for the sector-read sequencer
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        num_d       = num_q;
        scount_d    = scount_q;
        spurious_d  = spurious_q;
        stop_pend_d = stop_pend_q;
        bcnt_d      = bcnt_q;
        push_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_in) begin
                    state_d     = S_WAIT_READY;
                    addr_d      = start_addr_in;
                    num_d       = num_sectors_in;
                    scount_d    = 16'd0;
                    spurious_d  = 1'b0;
                    stop_pend_d = 1'b0;
                    bcnt_d      = {BCNT_W{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT_READY: begin
                // A whole sector must fit: sd_controller cannot be back-pressured
                if (stop_in || stop_pend_q) begin
                    state_d = S_DONE;
                end else if (sd_ready_in && (free_s >= SECTOR_SPACE)) begin
                    state_d = S_ISSUE;
                end else begin
                    state_d = S_WAIT_READY;
                end
            end
            S_ISSUE: begin
                if (!sd_ready_in) begin
                    state_d = S_RECEIVE;
                    bcnt_d  = {BCNT_W{1'b0}};
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_RECEIVE: begin
                if (strobe_edge_s) begin
                    push_d = 1'b1;
                end else begin
                    push_d = 1'b0;
                end
                // Count on the write cycle so NEXT follows the last FIFO write
                if (push_q) begin
                    if (bcnt_q == LAST_BYTE) begin
                        state_d = S_NEXT;
                        bcnt_d  = {BCNT_W{1'b0}};
                    end else begin
                        bcnt_d = bcnt_q + BCNT_W'(1);
                    end
                end else begin
                    bcnt_d = bcnt_q;
                end
            end
            S_NEXT: begin
                addr_d   = addr_q + ADDR_INC;
                scount_d = scount_q + 16'd1;
                if (((num_q != 16'd0) && (scount_d == num_q)) || stop_pend_q || stop_in) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_WAIT_READY;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (stop_in && (state_q != S_IDLE)) begin
            stop_pend_d = 1'b1;
        end else begin
            stop_pend_d = stop_pend_d;
        end

        // Strobes in IDLE are ignored silently; outside RECEIVE while busy they are flagged
        if (strobe_edge_s && (state_q != S_IDLE) && (state_q != S_RECEIVE)) begin
            spurious_d = 1'b1;
        end else begin
            spurious_d = spurious_d;
        end
    end

    // FIFO occupancy: simultaneous push and pop leaves the fill level unchanged
    always_comb begin
        fill_d = fill_q;
        case ({write_s, pop_s})
            2'b10:   fill_d = fill_q + (PTR_W+1)'(1);
            2'b01:   fill_d = fill_q - (PTR_W+1)'(1);
            default: fill_d = fill_q;
        endcase
    end

    // Sequencer, capture and pointer registers
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'd0;
            num_q        <= 16'd0;
            scount_q     <= 16'd0;
            spurious_q   <= 1'b0;
            stop_pend_q  <= 1'b0;
            bcnt_q       <= {BCNT_W{1'b0}};
            avail_prev_q <= 1'b0;
            push_q       <= 1'b0;
            push_data_q  <= 8'd0;
            wr_ptr_q     <= {PTR_W{1'b0}};
            rd_ptr_q     <= {PTR_W{1'b0}};
            fill_q       <= {(PTR_W+1){1'b0}};
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            num_q        <= num_d;
            scount_q     <= scount_d;
            spurious_q   <= spurious_d;
            stop_pend_q  <= stop_pend_d;
            bcnt_q       <= bcnt_d;
            avail_prev_q <= sd_byte_available_in;
            push_q       <= push_d;
            push_data_q  <= push_d ? sd_dout_in : push_data_q;
            wr_ptr_q     <= write_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
            rd_ptr_q     <= pop_s ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
            fill_q       <= fill_d;
        end
    end

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clk_in) begin
        if (write_s) begin
            mem_q[wr_ptr_q] <= push_data_q;
        end
    end

`ifdef SD_STREAM_CHECKSUM_EN
    logic [15:0] checksum_q;

    // Running byte sum of every FIFO write since start
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            checksum_q <= 16'd0;
        end else if ((state_q == S_IDLE) && start_in) begin
            checksum_q <= 16'd0;
        end else if (write_s) begin
            checksum_q <= checksum_q + {8'd0, push_data_q};
        end else begin
            checksum_q <= checksum_q;
        end
    end

    assign checksum_out = checksum_q;
`else
    assign checksum_out = 16'd0;
`endif

    assign sd_rd_out        = (state_q == S_ISSUE);
    assign sd_addr_out      = addr_q;
    assign busy_out         = (state_q != S_IDLE);
    assign done_out         = (state_q == S_DONE);
    assign sector_count_out = scount_q;
    assign spurious_out     = spurious_q;
    assign valid_out        = not_empty_s;
    // First-word fall-through; forced to zero when empty so reset shows 0
    assign data_out         = not_empty_s ? mem_q[rd_ptr_q] : 8'd0;

endmodule

// File: tb/tb_sd_sector_streamer.sv
// -----------------------------------------------------------------------------
// tb_sd_sector_streamer
//
// Directed bench: an sd_controller behavioural model serves sectors of a
// running byte pattern and pushes each served byte to a scoreboard queue; a
// consumer monitor pops and compares every transferred stream byte.
// -----------------------------------------------------------------------------
module tb_sd_sector_streamer;

    localparam int SECTOR = 512;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        start_in = 1'b0;
    logic [31:0] start_addr_in = 32'd0;
    logic [15:0] num_sectors_in = 16'd0;
    logic        stop_in = 1'b0;
    logic        sd_ready_in = 1'b1;
    logic        sd_byte_available_in = 1'b0;
    logic [7:0]  sd_dout_in = 8'd0;
    logic        sd_rd_out;
    logic [31:0] sd_addr_out;
    logic [7:0]  data_out;
    logic        valid_out;
    logic        ready_in = 1'b0;
    logic        busy_out;
    logic        done_out;
    logic [15:0] sector_count_out;
    logic        spurious_out;
    logic [15:0] checksum_out;

    sd_sector_streamer dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .start_in             (start_in),
        .start_addr_in        (start_addr_in),
        .num_sectors_in       (num_sectors_in),
        .stop_in              (stop_in),
        .sd_ready_in          (sd_ready_in),
        .sd_byte_available_in (sd_byte_available_in),
        .sd_dout_in           (sd_dout_in),
        .sd_rd_out            (sd_rd_out),
        .sd_addr_out          (sd_addr_out),
        .data_out             (data_out),
        .valid_out            (valid_out),
        .ready_in             (ready_in),
        .busy_out             (busy_out),
        .done_out             (done_out),
        .sector_count_out     (sector_count_out),
        .spurious_out         (spurious_out),
        .checksum_out         (checksum_out)
    );

    always #5 clk_in = ~clk_in;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  sb[$];
    logic [31:0] addr_log[$];
    int          done_count = 0;
    int          rd_rise = 0;
    int          bytes_out = 0;
    logic        rd_prev = 1'b0;
    int          bfm_byte = 0;
    logic [15:0] exp_sum = 16'd0;
    logic        sb_en = 1'b1;
    logic        bfm_busy = 1'b0;
    logic        inject_req = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    function automatic logic [31:0] log_at(input int idx);
        if (idx < addr_log.size()) return addr_log[idx];
        else return 32'hBAD0_BAD0;
    endfunction

    function automatic logic [15:0] exp_checksum();
`ifdef SD_STREAM_CHECKSUM_EN
        return exp_sum;
`else
        return 16'd0;
`endif
    endfunction

    // sd_controller model: serves one sector per request, optionally injects a stray strobe
    initial begin
        forever begin
            tick();
            if (inject_req && !bfm_busy) begin
                sd_dout_in = 8'hAA;
                sd_byte_available_in = 1'b1;
                tick(); tick();
                sd_byte_available_in = 1'b0;
                tick(); tick();
                inject_req = 1'b0;
            end else if (sd_rd_out && sd_ready_in) begin
                addr_log.push_back(sd_addr_out);
                bfm_busy = 1'b1;
                sd_ready_in = 1'b0;
                tick(); tick();
                for (int i = 0; i < SECTOR; i++) begin
                    sd_dout_in = bfm_byte[7:0];
                    if (sb_en) sb.push_back(bfm_byte[7:0]);
                    exp_sum = exp_sum + {8'd0, bfm_byte[7:0]};
                    bfm_byte++;
                    sd_byte_available_in = 1'b1;
                    tick(); tick();
                    sd_byte_available_in = 1'b0;
                    tick();
                end
                sd_ready_in = 1'b1;
                bfm_busy = 1'b0;
            end
        end
    end

    // Consumer monitor: compares each transferred byte with the scoreboard head
    always @(negedge clk_in) begin
        if (done_out) done_count++;
        if (sd_rd_out && !rd_prev) rd_rise++;
        rd_prev = sd_rd_out;
        if (valid_out && ready_in) begin
            bytes_out++;
            if (sb.size() == 0) begin
                check("unexpected_byte", 32'(sb.size()), 32'd1);
            end else begin
                check("stream_byte", {24'd0, data_out}, {24'd0, sb.pop_front()});
            end
        end
    end

    task automatic clear_book();
        done_count = 0;
        rd_rise = 0;
        bytes_out = 0;
        bfm_byte = 0;
        exp_sum = 16'd0;
        addr_log.delete();
    endtask

    task automatic do_start(input logic [31:0] addr, input logic [15:0] num);
        start_addr_in = addr;
        num_sectors_in = num;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
    endtask

    task automatic wait_done(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (done_count < target && n < limit) begin tick(); n++; end
        check(tag, done_count, target);
    endtask

    task automatic wait_rd(input int target, input int limit, input string tag);
        int n;
        n = 0;
        while (rd_rise < target && n < limit) begin tick(); n++; end
        check(tag, rd_rise, target);
    endtask

    task automatic wait_drain(input int limit, input string tag);
        int n;
        n = 0;
        while ((valid_out || bfm_busy || sb.size() != 0) && n < limit) begin tick(); n++; end
        check(tag, {31'd0, valid_out}, 32'd0);
    endtask

    task automatic wait_bfm_idle(input int limit, input string tag);
        int n;
        n = 0;
        while (bfm_busy && n < limit) begin tick(); n++; end
        check(tag, {31'd0, bfm_busy}, 32'd0);
    endtask

    initial begin
        // ---------------- reset values ----------------
        rst_in = 1'b1;
        repeat (3) tick();
        rst_in = 1'b0;
        check("rst_sd_rd", {31'd0, sd_rd_out}, 32'd0);
        check("rst_addr", sd_addr_out, 32'd0);
        check("rst_valid", {31'd0, valid_out}, 32'd0);
        check("rst_data", {24'd0, data_out}, 32'd0);
        check("rst_busy", {31'd0, busy_out}, 32'd0);
        check("rst_done", {31'd0, done_out}, 32'd0);
        check("rst_scount", {16'd0, sector_count_out}, 32'd0);
        check("rst_spurious", {31'd0, spurious_out}, 32'd0);
        check("rst_checksum", {16'd0, checksum_out}, 32'd0);

        // ---------------- two sectors from 0x200, start while busy ignored ----------------
        clear_book();
        ready_in = 1'b1;
        do_start(32'h0000_0200, 16'd2);
        tick();
        check("t1_rd_latency", {31'd0, sd_rd_out}, 32'd1);
        check("t1_addr0", sd_addr_out, 32'h0000_0200);
        check("t1_busy", {31'd0, busy_out}, 32'd1);
        repeat (200) tick();
        do_start(32'hDEAD_0000, 16'd7);
        check("t1_busy_start_addr", sd_addr_out, 32'h0000_0200);
        wait_done(1, 8000, "t1_done_timeout");
        wait_drain(3000, "t1_drain");
        repeat (20) tick();
        check("t1_done_count", done_count, 32'd1);
        check("t1_bytes", bytes_out, 32'd1024);
        check("t1_requests", rd_rise, 32'd2);
        check("t1_log_addr0", log_at(0), 32'h0000_0200);
        check("t1_log_addr1", log_at(1), 32'h0000_0400);
        check("t1_scount", {16'd0, sector_count_out}, 32'd2);
        check("t1_busy_end", {31'd0, busy_out}, 32'd0);
        check("t1_checksum", {16'd0, checksum_out}, {16'd0, exp_checksum()});

        // ---------------- stalled consumer, 4 sectors ----------------
        clear_book();
        ready_in = 1'b0;
        do_start(32'h0000_1000, 16'd4);
        wait_rd(2, 6000, "t2_two_requests");
        wait_bfm_idle(3000, "t2_bfm_idle");
        repeat (100) tick();
        check("t2_stalled_requests", rd_rise, 32'd2);
        check("t2_stalled_bytes", bytes_out, 32'd0);
        check("t2_full_valid", {31'd0, valid_out}, 32'd1);
        check("t2_spurious_before", {31'd0, spurious_out}, 32'd0);
        inject_req = 1'b1;
        begin
            int n;
            n = 0;
            while (inject_req && n < 100) begin tick(); n++; end
        end
        check("t2_spurious_set", {31'd0, spurious_out}, 32'd1);
        ready_in = 1'b1;
        repeat (511) tick();
        ready_in = 1'b0;
        repeat (50) tick();
        check("t2_511_bytes", bytes_out, 32'd511);
        check("t2_no_third_req", rd_rise, 32'd2);
        ready_in = 1'b1;
        tick();
        ready_in = 1'b0;
        repeat (20) tick();
        check("t2_512_bytes", bytes_out, 32'd512);
        check("t2_third_req", rd_rise, 32'd3);
        ready_in = 1'b1;
        wait_done(1, 15000, "t2_done_timeout");
        wait_drain(3000, "t2_drain");
        check("t2_bytes", bytes_out, 32'd2048);
        check("t2_requests", rd_rise, 32'd4);
        check("t2_scount", {16'd0, sector_count_out}, 32'd4);
        check("t2_spurious_sticky", {31'd0, spurious_out}, 32'd1);
        check("t2_checksum", {16'd0, checksum_out}, {16'd0, exp_checksum()});

        // ---------------- continuous mode, stop mid sector 3 ----------------
        clear_book();
        do_start(32'h0000_0000, 16'd0);
        check("t3_spurious_cleared", {31'd0, spurious_out}, 32'd0);
        wait_rd(3, 8000, "t3_third_req");
        repeat (400) tick();
        check("t3_scount_mid", {16'd0, sector_count_out}, 32'd2);
        stop_in = 1'b1;
        tick();
        stop_in = 1'b0;
        wait_done(1, 4000, "t3_done_timeout");
        wait_drain(3000, "t3_drain");
        repeat (300) tick();
        check("t3_bytes", bytes_out, 32'd1536);
        check("t3_requests", rd_rise, 32'd3);
        check("t3_scount", {16'd0, sector_count_out}, 32'd3);
        check("t3_done_count", done_count, 32'd1);
        check("t3_busy_end", {31'd0, busy_out}, 32'd0);

        // ---------------- reset during RECEIVE ----------------
        clear_book();
        do_start(32'h0000_3000, 16'd2);
        wait_rd(1, 100, "t4_req");
        repeat (100) tick();
        check("t4_busy_receive", {31'd0, busy_out}, 32'd1);
        sb_en = 1'b0;
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
        sb.delete();
        check("t4_rst_sd_rd", {31'd0, sd_rd_out}, 32'd0);
        check("t4_rst_addr", sd_addr_out, 32'd0);
        check("t4_rst_valid", {31'd0, valid_out}, 32'd0);
        check("t4_rst_data", {24'd0, data_out}, 32'd0);
        check("t4_rst_busy", {31'd0, busy_out}, 32'd0);
        check("t4_rst_scount", {16'd0, sector_count_out}, 32'd0);
        check("t4_rst_checksum", {16'd0, checksum_out}, 32'd0);
        wait_bfm_idle(3000, "t4_bfm_idle");
        repeat (10) tick();
        check("t4_late_spurious", {31'd0, spurious_out}, 32'd0);
        check("t4_late_valid", {31'd0, valid_out}, 32'd0);
        check("t4_late_busy", {31'd0, busy_out}, 32'd0);
        check("t4_late_requests", rd_rise, 32'd1);
        sb_en = 1'b1;

        // ---------------- address wrap ----------------
        clear_book();
        do_start(32'hFFFF_FE00, 16'd2);
        wait_done(1, 8000, "t7_done_timeout");
        wait_drain(3000, "t7_drain");
        check("t7_log_addr0", log_at(0), 32'hFFFF_FE00);
        check("t7_log_addr1", log_at(1), 32'h0000_0000);
        check("t7_final_addr", sd_addr_out, 32'h0000_0200);
        check("t7_scount", {16'd0, sector_count_out}, 32'd2);
        check("t7_bytes", bytes_out, 32'd1024);
        check("t7_checksum", {16'd0, checksum_out}, {16'd0, exp_checksum()});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
